// File: rtl/line_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_arb_pkg
// Description : Shared types and constants for the cacheline arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package line_arb_pkg;

  // Arbitration policy selectors for the PRIO_MODE parameter
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Arbiter control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/arb_picker.sv
`default_nettype none
// ============================================================================
// Module      : arb_picker
// Description : Combinational winner selection over a pending vector.
//               mode_i=0: rotating search from start_i, wrapping at the top.
//               mode_i=1: lowest pending index wins, start_i is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_picker #(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]         pending_i,
  input  logic [$clog2(NUM_PORTS)-1:0] start_i,
  input  logic                         mode_i,
  output logic                         valid_o,
  output logic [$clog2(NUM_PORTS)-1:0] idx_o
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  int unsigned cand;

  // Scan from the farthest candidate down to the nearest so the nearest
  // pending port is the last one written and therefore wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (mode_i) begin
        cand = unsigned'(k);
      end else begin
        cand = (unsigned'(int'(start_i)) + unsigned'(k)) % unsigned'(NUM_PORTS);
      end
      if (pending_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/line_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : line_arbiter
// Description : Arbitrates cacheline read/write requests from NUM_PORTS
//               requesters onto a single cacheline adaptor port. One request
//               is in flight at a time: IDLE -> ISSUE -> DONE -> IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module line_arbiter
  import line_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int PRIO_MODE  = 0
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_PORTS-1:0]                  req_read,
  input  logic [NUM_PORTS-1:0]                  req_write,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]                  req_resp,
  output logic [LINE_WIDTH-1:0]                 req_rdata,
  output logic                                  mem_read,
  output logic                                  mem_write,
  output logic [ADDR_WIDTH-1:0]                 mem_address,
  output logic [LINE_WIDTH-1:0]                 mem_wdata,
  input  logic [LINE_WIDTH-1:0]                 mem_rdata,
  input  logic                                  mem_resp,
  output logic [$clog2(NUM_PORTS)-1:0]          grant_idx,
  output logic                                  busy
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  state_e                  state_q;
  logic [IDX_W-1:0]        grant_idx_q;
  logic [IDX_W-1:0]        rr_ptr_q;     // last granted port, seeds the rotation
  logic                    op_write_q;
  logic                    mem_read_q;
  logic                    mem_write_q;
  logic [ADDR_WIDTH-1:0]   mem_address_q;
  logic [LINE_WIDTH-1:0]   mem_wdata_q;
  logic [LINE_WIDTH-1:0]   req_rdata_q;
  logic [NUM_PORTS-1:0]    req_resp_q;
  logic                    busy_q;

  logic [NUM_PORTS-1:0]    pending;
  logic [IDX_W-1:0]        rr_start;
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;

  // A port is pending if it asks for either operation; the rotating search
  // begins just after the last winner and wraps to port 0.
  always_comb begin
    pending  = req_read | req_write;
    rr_start = (rr_ptr_q == LAST_PORT) ? '0 : rr_ptr_q + IDX_W'(1);
  end

  arb_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .pending_i (pending),
    .start_i   (rr_start),
    .mode_i    (PRIO_MODE == PRIO_FIXED),
    .valid_o   (pick_valid),
    .idx_o     (pick_idx)
  );

  // Control FSM; every output is a register so the adaptor sees clean levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      grant_idx_q   <= '0;
      rr_ptr_q      <= LAST_PORT;
      op_write_q    <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      req_rdata_q   <= '0;
      req_resp_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_resp_q <= '0;
          if (pick_valid) begin
            // Write wins when a port raises both read and write
            grant_idx_q   <= pick_idx;
            rr_ptr_q      <= pick_idx;
            op_write_q    <= req_write[pick_idx];
            mem_read_q    <= ~req_write[pick_idx];
            mem_write_q   <= req_write[pick_idx];
            mem_address_q <= req_addr[pick_idx];
            mem_wdata_q   <= req_wdata[pick_idx];
            busy_q        <= 1'b1;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Requester inputs are not looked at here; only the adaptor matters
          if (mem_resp) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (!op_write_q) begin
              req_rdata_q <= mem_rdata;
            end
            req_resp_q  <= NUM_PORTS'(1) << grant_idx_q;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Completion pulse lasts this one cycle; no grant is made here
          req_resp_q <= '0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_resp    = req_resp_q;
  assign req_rdata   = req_rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign grant_idx   = grant_idx_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_arbiter
// Description : Self-checking bench for line_arbiter. Three instances share a
//               clock and reset: 2-port round-robin (a), 4-port round-robin (b)
//               and 4-port fixed priority (c). Expected completions are queued
//               when requests are driven and popped when req_resp fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_arbiter;

  typedef struct {
    int             port;
    bit             chk_rdata;
    logic [255:0]   rdata;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  // ---------------- instance a: 2 ports, round-robin ----------------
  logic [1:0]          ra_read = '0, ra_write = '0, ra_resp;
  logic [1:0][31:0]    ra_addr = '0;
  logic [1:0][255:0]   ra_wdata = '0;
  logic [255:0]        ra_rdata, ma_wdata;
  logic [255:0]        ma_rdata = '0;
  logic                ma_read, ma_write, a_busy;
  logic                ma_resp = 1'b0;
  logic [31:0]         ma_addr;
  logic [0:0]          ga_idx;

  line_arbiter #(.NUM_PORTS(2), .LINE_WIDTH(256), .ADDR_WIDTH(32), .PRIO_MODE(0)) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .req_read(ra_read), .req_write(ra_write), .req_addr(ra_addr), .req_wdata(ra_wdata),
    .req_resp(ra_resp), .req_rdata(ra_rdata),
    .mem_read(ma_read), .mem_write(ma_write), .mem_address(ma_addr), .mem_wdata(ma_wdata),
    .mem_rdata(ma_rdata), .mem_resp(ma_resp), .grant_idx(ga_idx), .busy(a_busy)
  );

  // ---------------- instance b: 4 ports, round-robin ----------------
  logic [3:0]          rb_read = '0, rb_write = '0, rb_resp;
  logic [3:0][31:0]    rb_addr = '0;
  logic [3:0][255:0]   rb_wdata = '0;
  logic [255:0]        rb_rdata, mb_wdata;
  logic [255:0]        mb_rdata = '0;
  logic                mb_read, mb_write, b_busy;
  logic                mb_resp = 1'b0;
  logic [31:0]         mb_addr;
  logic [1:0]          gb_idx;
  int                  cnt_b = 0;

  line_arbiter #(.NUM_PORTS(4), .LINE_WIDTH(256), .ADDR_WIDTH(32), .PRIO_MODE(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .req_read(rb_read), .req_write(rb_write), .req_addr(rb_addr), .req_wdata(rb_wdata),
    .req_resp(rb_resp), .req_rdata(rb_rdata),
    .mem_read(mb_read), .mem_write(mb_write), .mem_address(mb_addr), .mem_wdata(mb_wdata),
    .mem_rdata(mb_rdata), .mem_resp(mb_resp), .grant_idx(gb_idx), .busy(b_busy)
  );

  // ---------------- instance c: 4 ports, fixed priority ----------------
  logic [3:0]          rc_read = '0, rc_write = '0, rc_resp;
  logic [3:0][31:0]    rc_addr = '0;
  logic [3:0][255:0]   rc_wdata = '0;
  logic [255:0]        rc_rdata, mc_wdata;
  logic [255:0]        mc_rdata = '0;
  logic                mc_read, mc_write, c_busy;
  logic                mc_resp = 1'b0;
  logic [31:0]         mc_addr;
  logic [1:0]          gc_idx;
  int                  cnt_c = 0;

  line_arbiter #(.NUM_PORTS(4), .LINE_WIDTH(256), .ADDR_WIDTH(32), .PRIO_MODE(1)) u_dut_c (
    .clk(clk), .reset_n(reset_n),
    .req_read(rc_read), .req_write(rc_write), .req_addr(rc_addr), .req_wdata(rc_wdata),
    .req_resp(rc_resp), .req_rdata(rc_rdata),
    .mem_read(mc_read), .mem_write(mc_write), .mem_address(mc_addr), .mem_wdata(mc_wdata),
    .mem_rdata(mc_rdata), .mem_resp(mc_resp), .grant_idx(gc_idx), .busy(c_busy)
  );

  // Adaptor models for b and c: answer on the second request cycle with
  // a line built from the requested address.
  always @(negedge clk) begin
    if (mb_resp) begin
      mb_resp = 1'b0;
      cnt_b   = 0;
    end else if (mb_read || mb_write) begin
      cnt_b = cnt_b + 1;
      if (cnt_b == 2) begin
        mb_resp  = 1'b1;
        mb_rdata = {8{mb_addr}};
      end
    end
  end

  always @(negedge clk) begin
    if (mc_resp) begin
      mc_resp = 1'b0;
      cnt_c   = 0;
    end else if (mc_read || mc_write) begin
      cnt_c = cnt_c + 1;
      if (cnt_c == 2) begin
        mc_resp  = 1'b1;
        mc_rdata = {8{mc_addr}};
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({ma_read, ma_write, ra_resp, a_busy, ga_idx} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: rd=%b wr=%b resp=%b busy=%b gidx=%b, required all 0",
               ma_read, ma_write, ra_resp, a_busy, ga_idx);
    end
    total++;
    if (ma_addr !== 32'h0 || ma_wdata !== 256'h0 || ra_rdata !== 256'h0) begin
      bad++;
      $display("FAIL reset_data: addr=%h wdata_nz=%b rdata_nz=%b, required zero",
               ma_addr, |ma_wdata, |ra_rdata);
    end
    total++;
    if (b_busy !== 1'b0 || gb_idx !== 2'd0 || rb_resp !== 4'd0) begin
      bad++;
      $display("FAIL reset_b: busy=%b gidx=%0d resp=%b, required 0", b_busy, gb_idx, rb_resp);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    exp_t e;
    logic [1:0] er;
    @(negedge clk);                       // cycle 0
    ra_read[1] = 1'b1;
    ra_addr[1] = 32'h40;
    e.port = 1; e.chk_rdata = 1'b1; e.rdata = {32{8'hA5}};
    sb.push_back(e);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if (ma_read !== 1'b1 || ma_write !== 1'b0 || ma_addr !== 32'h40) begin
        bad++;
        $display("FAIL single_mem_req c%0d: rd=%b wr=%b addr=%h, required 1/0/00000040",
                 c, ma_read, ma_write, ma_addr);
      end
      if (c == 4) begin
        ma_resp  = 1'b1;
        ma_rdata = {32{8'hA5}};
      end
    end
    @(negedge clk);                       // cycle 5
    ma_resp  = 1'b0;
    ma_rdata = '0;
    e  = sb.pop_front();
    er = '0;
    er[e.port] = 1'b1;
    total++;
    if (ra_resp !== er || ra_rdata !== e.rdata || ma_read !== 1'b0) begin
      bad++;
      $display("FAIL single_resp: resp=%b rdata=%h mem_read=%b, required %b %h 0",
               ra_resp, ra_rdata, ma_read, er, e.rdata);
    end
    ra_read = '0;
    @(negedge clk);                       // cycle 6
    total++;
    if (a_busy !== 1'b0 || ra_resp !== 2'b00) begin
      bad++;
      $display("FAIL single_idle: busy=%b resp=%b, required 0 00", a_busy, ra_resp);
    end
  endtask

  task automatic test_addr_hold();
    exp_t e;
    logic [1:0] er;
    @(negedge clk);                       // cycle 0
    ra_read[0] = 1'b1;
    ra_addr[0] = 32'h100;
    e.port = 0; e.chk_rdata = 1'b1; e.rdata = {32{8'h5A}};
    sb.push_back(e);
    @(negedge clk);                       // cycle 1
    total++;
    if (ma_addr !== 32'h100 || ga_idx !== 1'b0) begin
      bad++;
      $display("FAIL hold_grant: addr=%h gidx=%0d, required 00000100 0", ma_addr, ga_idx);
    end
    ra_addr[0] = 32'h200;
    ra_read[1] = 1'b1;
    ra_addr[1] = 32'h999;
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if (ma_addr !== 32'h100 || ma_read !== 1'b1 || ga_idx !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable c%0d: addr=%h rd=%b gidx=%0d, required 00000100 1 0",
                 c, ma_addr, ma_read, ga_idx);
      end
      if (c == 3) begin
        ma_resp  = 1'b1;
        ma_rdata = {32{8'h5A}};
      end
    end
    @(negedge clk);                       // cycle 4
    ma_resp = 1'b0;
    e  = sb.pop_front();
    er = '0;
    er[e.port] = 1'b1;
    total++;
    if (ra_resp !== er || ra_rdata !== e.rdata) begin
      bad++;
      $display("FAIL hold_resp: resp=%b rdata=%h, required %b %h", ra_resp, ra_rdata, er, e.rdata);
    end
    ra_read = '0;
    @(negedge clk);                       // cycle 5
    total++;
    if (a_busy !== 1'b0 || ma_read !== 1'b0) begin
      bad++;
      $display("FAIL hold_idle: busy=%b rd=%b, required 0 0", a_busy, ma_read);
    end
  endtask

  task automatic test_rw_both();
    exp_t e;
    logic [1:0] er;
    @(negedge clk);                       // cycle 0
    ra_read[1]  = 1'b1;
    ra_write[1] = 1'b1;
    ra_addr[1]  = 32'h80;
    ra_wdata[1] = {32{8'hFF}};
    e.port = 1; e.chk_rdata = 1'b0; e.rdata = '0;
    sb.push_back(e);
    @(negedge clk);                       // cycle 1
    total++;
    if (ma_write !== 1'b1 || ma_read !== 1'b0 || ma_wdata !== {32{8'hFF}} ||
        ma_addr !== 32'h80 || ga_idx !== 1'b1) begin
      bad++;
      $display("FAIL rw_issue: wr=%b rd=%b wdata=%h addr=%h gidx=%0d, required 1 0 ff.. 00000080 1",
               ma_write, ma_read, ma_wdata, ma_addr, ga_idx);
    end
    ma_resp = 1'b1;
    @(negedge clk);                       // cycle 2
    ma_resp = 1'b0;
    e  = sb.pop_front();
    er = '0;
    er[e.port] = 1'b1;
    total++;
    if (ra_resp !== er || ma_write !== 1'b0) begin
      bad++;
      $display("FAIL rw_resp: resp=%b wr=%b, required %b 0", ra_resp, ma_write, er);
    end
    ra_read  = '0;
    ra_write = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    exp_t       e;
    logic [3:0] er;
    logic [31:0] a;
    int got = 0;
    int order[6] = '{0, 1, 2, 3, 0, 1};
    for (int p = 0; p < 4; p++) rb_addr[p] = 32'(p * 16);
    rb_read = 4'hF;
    for (int i = 0; i < 6; i++) begin
      a = 32'(order[i] * 16);
      e.port = order[i]; e.chk_rdata = 1'b1; e.rdata = {8{a}};
      sb.push_back(e);
    end
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      @(negedge clk);
      if (rb_resp !== 4'b0) begin
        e  = sb.pop_front();
        er = 4'b0001 << e.port;
        total++;
        if (rb_resp !== er || rb_rdata !== e.rdata) begin
          bad++;
          $display("FAIL rr_order #%0d: resp=%b rdata=%h, required %b %h",
                   got, rb_resp, rb_rdata, er, e.rdata);
        end
        got++;
        if (got == 6) rb_read = '0;
      end
    end
    total++;
    if (got != 6) begin
      bad++;
      $display("FAIL rr_timeout: completions=%0d, required 6", got);
      sb.delete();
    end
    repeat (3) @(negedge clk);
    total++;
    if (b_busy !== 1'b0) begin
      bad++;
      $display("FAIL rr_idle: busy=%b, required 0", b_busy);
    end
  endtask

  task automatic test_fixed();
    exp_t       e;
    logic [3:0] er;
    int got = 0;
    rc_addr[0] = 32'h1000;
    rc_addr[2] = 32'h2000;
    rc_read    = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      e.port = (i < 5) ? 0 : 2;
      e.chk_rdata = 1'b1;
      e.rdata = (i < 5) ? {8{32'h1000}} : {8{32'h2000}};
      sb.push_back(e);
    end
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      @(negedge clk);
      if (rc_resp !== 4'b0) begin
        e  = sb.pop_front();
        er = 4'b0001 << e.port;
        total++;
        if (rc_resp !== er || rc_rdata !== e.rdata) begin
          bad++;
          $display("FAIL fixed_grant #%0d: resp=%b rdata=%h, required %b %h",
                   got, rc_resp, rc_rdata, er, e.rdata);
        end
        got++;
        if (got == 5) rc_read[0] = 1'b0;
        if (got == 6) rc_read = '0;
      end
    end
    total++;
    if (got != 6) begin
      bad++;
      $display("FAIL fixed_timeout: completions=%0d, required 6", got);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_in_issue();
    exp_t e;
    logic [1:0] er;
    bit saw_resp = 1'b0;
    @(negedge clk);                       // cycle 0
    ra_read[0] = 1'b1;
    ra_addr[0] = 32'h300;
    @(negedge clk);                       // cycle 1: ISSUE
    @(negedge clk);                       // cycle 2
    total++;
    if (ma_read !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre: mem_read=%b, required 1", ma_read);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (ma_read !== 1'b0 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: mem_read=%b busy=%b, required 0 0", ma_read, a_busy);
    end
    ra_read = '0;
    #1 reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ra_resp !== 2'b00 || a_busy !== 1'b0) saw_resp = 1'b1;
    end
    total++;
    if (saw_resp) begin
      bad++;
      $display("FAIL rst_no_resp: activity seen after reset, required none");
    end
    // Contention: pointer reset must hand port 0 the first grant
    ra_read    = 2'b11;
    ra_addr[0] = 32'h500;
    ra_addr[1] = 32'h600;
    e.port = 0; e.chk_rdata = 1'b1; e.rdata = {8{32'h1111_0000}};
    sb.push_back(e);
    e.port = 1; e.chk_rdata = 1'b1; e.rdata = {8{32'h2222_0000}};
    sb.push_back(e);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      total++;
      if (ga_idx !== 1'(n) || ma_addr !== ((n == 0) ? 32'h500 : 32'h600) || ma_read !== 1'b1) begin
        bad++;
        $display("FAIL rst_contention #%0d: gidx=%0d addr=%h rd=%b, required %0d", n, ga_idx, ma_addr, ma_read, n);
      end
      ma_resp  = 1'b1;
      ma_rdata = (n == 0) ? {8{32'h1111_0000}} : {8{32'h2222_0000}};
      @(negedge clk);
      ma_resp = 1'b0;
      e  = sb.pop_front();
      er = '0;
      er[e.port] = 1'b1;
      total++;
      if (ra_resp !== er || ra_rdata !== e.rdata) begin
        bad++;
        $display("FAIL rst_contention_resp #%0d: resp=%b rdata=%h, required %b %h",
                 n, ra_resp, ra_rdata, er, e.rdata);
      end
      ra_read[n] = 1'b0;
      @(negedge clk);                     // back in IDLE
    end
    @(negedge clk);
    total++;
    if (a_busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_final_idle: busy=%b, required 0", a_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_addr_hold();
    test_rw_both();
    test_round_robin();
    test_fixed();
    test_reset_in_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
